// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - parametrised single-clock FIFO with programmable thresholds and sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_prog #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  FIFO_full,
  output logic                  FIFO_empty,
  output logic                  FIFO_almost_full,
  output logic                  FIFO_almost_empty,
  output logic [ADDR_WIDTH:0]   FIFO_counter,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_CNT   = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT   = AEMPTY_THRESH[ADDR_WIDTH:0];

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_prog: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_prog: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags only, so there is no same-cycle bypass.
  assign wr_acc = write_en & ~FIFO_full;
  assign rd_acc = read_en & ~FIFO_empty;

  assign FIFO_counter      = count;
  assign FIFO_full         = (count == FULL_CNT);
  assign FIFO_empty        = (count == '0);
  assign FIFO_almost_full  = (count >= AF_CNT);
  assign FIFO_almost_empty = (count <= AE_CNT);

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error event takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && FIFO_full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (read_en && FIFO_empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out   = FIFO_empty ? '0 : mem[rd_ptr];
  assign read_valid = ~FIFO_empty;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - randomized self-checking bench for sync_fifo_prog against a queue model
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       read_valid;
  logic       FIFO_full;
  logic       FIFO_empty;
  logic       FIFO_almost_full;
  logic       FIFO_almost_empty;
  logic [6:0] FIFO_counter;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  // Reference model: occupancy is the queue itself.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] m_dout = '0;
  logic       m_rv = 1'b0;

  sync_fifo_prog dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .err_clr(err_clr), .data_out(data_out),
    .read_valid(read_valid), .FIFO_full(FIFO_full), .FIFO_empty(FIFO_empty),
    .FIFO_almost_full(FIFO_almost_full), .FIFO_almost_empty(FIFO_almost_empty),
    .FIFO_counter(FIFO_counter), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle(input logic we, input logic re, input logic [7:0] din, input logic clr);
    bit wa, ra;
    write_en = we; read_en = re; data_in = din; err_clr = clr;
    wa = we && (q.size() < 64);
    ra = re && (q.size() != 0);
    if (we && q.size() == 64) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (re && q.size() == 0)  m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    m_rv = ra;
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(din);
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0; err_clr = 1'b0;
  endtask

  // Other inputs are held active during reset to show that reset dominates.
  task automatic do_reset(input int n);
    rst = 1'b1; write_en = 1'b1; read_en = 1'b1; err_clr = 1'b0; data_in = 8'h5A;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0; m_rv = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(2);
    checks++; if (FIFO_counter !== 7'd0) begin errors++; $display("FAIL reset_counter: got %0d need 0", FIFO_counter); end
    checks++; if (FIFO_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b need 1", FIFO_empty); end
    checks++; if (FIFO_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b need 1", FIFO_almost_empty); end
    checks++; if ({FIFO_full, FIFO_almost_full} !== 2'b00) begin errors++; $display("FAIL reset_full_flags: got %b need 00", {FIFO_full, FIFO_almost_full}); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h need 00", data_out); end
    checks++; if ({read_valid, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL reset_rv_err: got %b need 000", {read_valid, overflow, underflow}); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b0);
      checks++; if (FIFO_counter !== 7'(i + 1)) begin errors++; $display("FAIL fill_counter: got %0d need %0d", FIFO_counter, i + 1); end
      checks++; if (FIFO_almost_full !== (i + 1 >= 56)) begin errors++; $display("FAIL fill_afull at %0d: got %b need %b", i + 1, FIFO_almost_full, (i + 1 >= 56)); end
      checks++; if (FIFO_full !== (i + 1 == 64)) begin errors++; $display("FAIL fill_full at %0d: got %b need %b", i + 1, FIFO_full, (i + 1 == 64)); end
      checks++; if (FIFO_almost_empty !== (i + 1 <= 8)) begin errors++; $display("FAIL fill_aempty at %0d: got %b need %b", i + 1, FIFO_almost_empty, (i + 1 <= 8)); end
    end
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b need 1", overflow); end
    checks++; if (FIFO_counter !== 7'd64) begin errors++; $display("FAIL overflow_counter: got %0d need 64", FIFO_counter); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data: got %h need %h", data_out, 8'(i)); end
      checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL drain_rv: got %b need 1", read_valid); end
    end
    checks++; if (FIFO_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b need 1", FIFO_empty); end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b need 1", underflow); end
    checks++; if (data_out !== 8'd63) begin errors++; $display("FAIL underflow_hold: got %h need 3f", data_out); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL underflow_rv: got %b need 0", read_valid); end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL err_clr: got %b need 00", {overflow, underflow}); end
  endtask

  task automatic test_simultaneous;
    do_reset(1);
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
      checks++; if (FIFO_counter !== 7'd32) begin errors++; $display("FAIL simul_counter: got %0d need 32", FIFO_counter); end
      checks++; if (data_out !== m_dout) begin errors++; $display("FAIL simul_order: got %h need %h", data_out, m_dout); end
    end
    while (q.size() < 64) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
    checks++; if (FIFO_counter !== 7'd63) begin errors++; $display("FAIL simul_full_counter: got %0d need 63", FIFO_counter); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL simul_full_ovf: got %b need 1", overflow); end
    checks++; if (data_out !== m_dout) begin errors++; $display("FAIL simul_full_data: got %h need %h", data_out, m_dout); end
    while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 8'hC3, 1'b0);
    checks++; if (FIFO_counter !== 7'd1) begin errors++; $display("FAIL simul_empty_counter: got %0d need 1", FIFO_counter); end
    checks++; if ({overflow, underflow} !== 2'b01) begin errors++; $display("FAIL simul_empty_err: got %b need 01", {overflow, underflow}); end
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL simul_empty_word: got %h need c3", data_out); end
  endtask

  task automatic test_wrap;
    do_reset(1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if (data_out !== 8'(8'h80 + i)) begin errors++; $display("FAIL wrap_data: got %h need %h", data_out, 8'(8'h80 + i)); end
    end
    checks++; if (FIFO_counter !== 7'd0) begin errors++; $display("FAIL wrap_counter: got %0d need 0", FIFO_counter); end
  endtask

  task automatic test_random;
    int pw, pr;
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      // Alternate fill-biased and drain-biased phases to reach both ends.
      pw = ((i / 100) % 2 == 0) ? 80 : 25;
      pr = 105 - pw;
      cycle($urandom_range(99) < pw, $urandom_range(99) < pr, 8'($urandom), $urandom_range(99) < 5);
      checks++; if (FIFO_counter !== 7'(q.size())) begin errors++; $display("FAIL rand_counter cyc %0d: got %0d need %0d", i, FIFO_counter, q.size()); end
      checks++; if ({FIFO_full, FIFO_empty, FIFO_almost_full, FIFO_almost_empty} !==
                    {q.size() == 64, q.size() == 0, q.size() >= 56, q.size() <= 8}) begin
        errors++; $display("FAIL rand_flags cyc %0d: got %b need %b", i,
          {FIFO_full, FIFO_empty, FIFO_almost_full, FIFO_almost_empty},
          {q.size() == 64, q.size() == 0, q.size() >= 56, q.size() <= 8});
      end
      checks++; if ({read_valid, data_out} !== {m_rv, m_dout}) begin errors++; $display("FAIL rand_read cyc %0d: got %b/%h need %b/%h", i, read_valid, data_out, m_rv, m_dout); end
      checks++; if ({overflow, underflow} !== {m_ovf, m_udf}) begin errors++; $display("FAIL rand_err cyc %0d: got %b need %b", i, {overflow, underflow}, {m_ovf, m_udf}); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    checks++; if (FIFO_counter !== 7'd20) begin errors++; $display("FAIL mid_pre_counter: got %0d need 20", FIFO_counter); end
    do_reset(1);
    checks++; if (FIFO_counter !== 7'd0) begin errors++; $display("FAIL mid_counter: got %0d need 0", FIFO_counter); end
    checks++; if (FIFO_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b need 1", FIFO_empty); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL mid_rv: got %b need 0", read_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
